// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator stage: opcodes, FSM states and the
// bit positions of the flags inside the internal flag vector.
package acc_pkg;

  localparam logic [2:0] OP_CLR = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_ADC = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_SBC = 3'd5;
  localparam logic [2:0] OP_CMP = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

endpackage

// File: rtl/add_sub.sv
// 8-bit ripple adder/subtractor: sum = a + (b ^ {8{m}}) + cin.
// With m=1 and cin=1 this is a - b; cout=1 then means no borrow.
module add_sub (
  input  logic       m,
  input  logic       cin,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] y;
  logic [8:0] carry;

  assign y        = b ^ {8{m}};
  assign carry[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign sum[i]     = a[i] ^ y[i] ^ carry[i];
    assign carry[i+1] = (a[i] & y[i]) | (carry[i] & (a[i] ^ y[i]));
  end

  assign cout = carry[8];

endmodule

// File: rtl/accumulator_unit.sv
// Accumulator and C/Z/N/V flag stage around add_sub: accept a command in
// IDLE, register the adder result in EXEC, write acc/flags back in WB.
module accumulator_unit
  import acc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [2:0] op_code,
  input  logic [7:0] operand,
  output logic [7:0] acc,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_v,
  output logic       done
);

  // Handshake: a command transfers on a rising edge where op_valid && op_ready.
  // op_ready is a register that is 1 exactly while the FSM sits in IDLE, so it
  // never depends on op_valid; the producer holds its command until accepted.

  state_t     state;
  logic [2:0] op_q;
  logic [7:0] operand_q;
  logic [3:0] flags;
  logic [7:0] res_q;
  logic       cout_q;
  logic       v_q;

  logic       m;
  logic       cin;
  logic [7:0] sum;
  logic       cout;
  logic       v_calc;

  // Carry-in is read from the live flag register in EXEC, after the previous
  // op's writeback, so chained ADC/SBC need no bypass.
  always_comb begin
    m   = 1'b0;
    cin = 1'b0;
    case (op_q)
      OP_ADC: cin = flags[FLAG_C];
      OP_SUB: begin m = 1'b1; cin = 1'b1; end
      OP_SBC: begin m = 1'b1; cin = flags[FLAG_C]; end
      OP_CMP: begin m = 1'b1; cin = 1'b1; end
      default: begin m = 1'b0; cin = 1'b0; end
    endcase
  end

  add_sub u_add_sub (
    .m    (m),
    .cin  (cin),
    .a    (acc),
    .b    (operand_q),
    .sum  (sum),
    .cout (cout)
  );

  assign v_calc = (acc[7] == (operand_q[7] ^ m)) && (sum[7] != acc[7]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_ready  <= 1'b1;
      done      <= 1'b0;
      acc       <= 8'h00;
      flags     <= 4'b0000;
      op_q      <= OP_NOP;
      operand_q <= 8'h00;
      res_q     <= 8'h00;
      cout_q    <= 1'b0;
      v_q       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (op_valid && op_ready) begin
            op_q      <= op_code;
            operand_q <= operand;
            op_ready  <= 1'b0;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_q  <= sum;
          cout_q <= cout;
          v_q    <= v_calc;
          state  <= ST_WB;
        end
        ST_WB: begin
          case (op_q)
            OP_CLR: begin
              acc   <= 8'h00;
              flags <= 4'b0000;
              flags[FLAG_Z] <= 1'b1;
            end
            OP_LDA: begin
              acc           <= operand_q;
              flags[FLAG_Z] <= (operand_q == 8'h00);
              flags[FLAG_N] <= operand_q[7];
            end
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
              acc           <= res_q;
              flags[FLAG_C] <= cout_q;
              flags[FLAG_Z] <= (res_q == 8'h00);
              flags[FLAG_N] <= res_q[7];
              flags[FLAG_V] <= v_q;
            end
            OP_CMP: begin
              flags[FLAG_C] <= cout_q;
              flags[FLAG_Z] <= (res_q == 8'h00);
              flags[FLAG_N] <= res_q[7];
            end
            default: begin
            end
          endcase
          done     <= 1'b1;
          op_ready <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          op_ready <= 1'b1;
          done     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign flag_c = flags[FLAG_C];
  assign flag_z = flags[FLAG_Z];
  assign flag_n = flags[FLAG_N];
  assign flag_v = flags[FLAG_V];

endmodule

// File: tb/tb_accumulator_unit.sv
// Bench for accumulator_unit: directed scenarios with fixed expectations plus
// random command streams checked against an integer-arithmetic model.
module tb_accumulator_unit;

  localparam logic [2:0] OP_CLR = 3'd0;
  localparam logic [2:0] OP_LDA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_ADC = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_SBC = 3'd5;
  localparam logic [2:0] OP_CMP = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  logic       clk;
  logic       rst;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_code;
  logic [7:0] operand;
  logic [7:0] acc;
  logic       flag_c;
  logic       flag_z;
  logic       flag_n;
  logic       flag_v;
  logic       done;

  int checks;
  int errors;

  // reference model state
  int m_acc;
  bit m_c, m_z, m_n, m_v;

  accumulator_unit dut (
    .clk      (clk),
    .rst      (rst),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_code  (op_code),
    .operand  (operand),
    .acc      (acc),
    .flag_c   (flag_c),
    .flag_z   (flag_z),
    .flag_n   (flag_n),
    .flag_v   (flag_v),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_signed8(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  function automatic void model_reset();
    m_acc = 0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
  endfunction

  function automatic void model_apply(input logic [2:0] op, input logic [7:0] val);
    int a, b, r, s, borrow;
    a = m_acc;
    b = int'(val);
    case (op)
      OP_CLR: begin m_acc = 0; m_c = 0; m_z = 1; m_n = 0; m_v = 0; end
      OP_LDA: begin m_acc = b; m_z = (b == 0); m_n = (b >= 128); end
      OP_ADD, OP_ADC: begin
        r = a + b + ((op == OP_ADC) ? int'(m_c) : 0);
        s = to_signed8(a) + to_signed8(b) + ((op == OP_ADC) ? int'(m_c) : 0);
        m_acc = r % 256;
        m_c = (r > 255);
        m_z = (m_acc == 0);
        m_n = (m_acc >= 128);
        m_v = (s > 127) || (s < -128);
      end
      OP_SUB, OP_SBC, OP_CMP: begin
        borrow = (op == OP_SBC) ? int'(!m_c) : 0;
        r = a - b - borrow;
        s = to_signed8(a) - to_signed8(b) - borrow;
        m_c = (r >= 0);
        m_z = (((r + 256) % 256) == 0);
        m_n = (((r + 256) % 256) >= 128);
        if (op != OP_CMP) begin
          m_acc = (r + 256) % 256;
          m_v = (s > 127) || (s < -128);
        end
      end
      default: begin
      end
    endcase
  endfunction

  // Drives one command and returns the number of cycles from the handshake
  // edge to the cycle in which done is seen high (-1 if it never shows).
  task automatic issue(input logic [2:0] op, input logic [7:0] val, output int lat);
    int n;
    lat = -1;
    n = 0;
    while (!op_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    op_valid = 1'b1;
    op_code  = op;
    operand  = val;
    @(posedge clk);
    model_apply(op, val);
    @(negedge clk);
    op_valid = 1'b0;
    op_code  = 3'($urandom_range(0, 7));
    operand  = 8'($urandom_range(0, 255));
    for (int i = 1; i <= 10; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    op_valid = 1'b0;
    op_code = OP_NOP;
    operand = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    int lat;
    do_reset();
    checks++;
    if ({acc, flag_c, flag_z, flag_n, flag_v, op_ready, done} !== {8'h00, 4'b0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got acc=%h cznv=%b%b%b%b ready=%b done=%b, want acc=00 cznv=0000 ready=1 done=0",
               acc, flag_c, flag_z, flag_n, flag_v, op_ready, done);
    end
    issue(OP_CLR, 8'h5A, lat);
    checks++;
    if ({acc, flag_c, flag_z, flag_n, flag_v} !== {8'h00, 4'b0100} || lat != 3) begin
      errors++;
      $display("FAIL reset_clr: got acc=%h cznv=%b%b%b%b lat=%0d, want acc=00 cznv=0100 lat=3",
               acc, flag_c, flag_z, flag_n, flag_v, lat);
    end
  endtask

  task automatic test_overflow();
    int lat1, lat2;
    issue(OP_LDA, 8'h7F, lat1);
    issue(OP_ADD, 8'h01, lat2);
    checks++;
    if ({acc, flag_c, flag_z, flag_n, flag_v} !== {8'h80, 4'b0011}) begin
      errors++;
      $display("FAIL overflow_add: got acc=%h cznv=%b%b%b%b, want acc=80 cznv=0011",
               acc, flag_c, flag_z, flag_n, flag_v);
    end
    checks++;
    if (lat1 != 3 || lat2 != 3) begin
      errors++;
      $display("FAIL overflow_latency: got %0d and %0d cycles, want 3 and 3", lat1, lat2);
    end
  endtask

  task automatic test_subtract();
    int lat;
    issue(OP_LDA, 8'h05, lat);
    issue(OP_SUB, 8'h05, lat);
    checks++;
    if ({acc, flag_c, flag_z, flag_n, flag_v} !== {8'h00, 4'b1100}) begin
      errors++;
      $display("FAIL sub_equal: got acc=%h cznv=%b%b%b%b, want acc=00 cznv=1100",
               acc, flag_c, flag_z, flag_n, flag_v);
    end
    issue(OP_SUB, 8'h01, lat);
    checks++;
    if ({acc, flag_c, flag_z, flag_n, flag_v} !== {8'hFF, 4'b0010}) begin
      errors++;
      $display("FAIL sub_borrow: got acc=%h cznv=%b%b%b%b, want acc=ff cznv=0010",
               acc, flag_c, flag_z, flag_n, flag_v);
    end
  endtask

  task automatic test_carry_chain();
    int lat;
    issue(OP_LDA, 8'hFF, lat);
    issue(OP_ADD, 8'h01, lat);
    checks++;
    if ({acc, flag_c, flag_z, flag_n, flag_v} !== {8'h00, 4'b1100}) begin
      errors++;
      $display("FAIL carry_add: got acc=%h cznv=%b%b%b%b, want acc=00 cznv=1100",
               acc, flag_c, flag_z, flag_n, flag_v);
    end
    issue(OP_ADC, 8'h00, lat);
    checks++;
    if ({acc, flag_c, flag_z, flag_n, flag_v} !== {8'h01, 4'b0000}) begin
      errors++;
      $display("FAIL carry_adc: got acc=%h cznv=%b%b%b%b, want acc=01 cznv=0000",
               acc, flag_c, flag_z, flag_n, flag_v);
    end
    issue(OP_SBC, 8'h01, lat);
    checks++;
    if ({acc, flag_c, flag_z, flag_n, flag_v} !== {8'hFF, 4'b0010}) begin
      errors++;
      $display("FAIL carry_sbc: got acc=%h cznv=%b%b%b%b, want acc=ff cznv=0010",
               acc, flag_c, flag_z, flag_n, flag_v);
    end
  endtask

  task automatic test_compare();
    int lat;
    issue(OP_LDA, 8'h7F, lat);
    issue(OP_ADD, 8'h01, lat);
    issue(OP_LDA, 8'h20, lat);
    issue(OP_CMP, 8'h10, lat);
    checks++;
    if ({acc, flag_c, flag_z, flag_n, flag_v} !== {8'h20, 4'b1001}) begin
      errors++;
      $display("FAIL compare: got acc=%h cznv=%b%b%b%b, want acc=20 cznv=1001",
               acc, flag_c, flag_z, flag_n, flag_v);
    end
    issue(OP_NOP, 8'h33, lat);
    checks++;
    if ({acc, flag_c, flag_z, flag_n, flag_v} !== {8'h20, 4'b1001} || lat != 3) begin
      errors++;
      $display("FAIL nop: got acc=%h cznv=%b%b%b%b lat=%0d, want acc=20 cznv=1001 lat=3",
               acc, flag_c, flag_z, flag_n, flag_v, lat);
    end
  endtask

  task automatic test_busy();
    int seen_done;
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = OP_LDA;
    operand  = 8'h11;
    @(posedge clk);
    model_apply(OP_LDA, 8'h11);
    @(negedge clk);
    op_code = OP_ADD;
    operand = 8'h22;
    checks++;
    if (op_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_ready_exec: got op_ready=%b, want 0", op_ready);
    end
    @(negedge clk);
    op_code = OP_CLR;
    op_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (acc !== 8'h11 || done !== 1'b1 || op_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_first_only: got acc=%h done=%b ready=%b, want acc=11 done=1 ready=1",
               acc, done, op_ready);
    end
    seen_done = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    checks++;
    if (acc !== 8'h11 || seen_done != 0) begin
      errors++;
      $display("FAIL busy_ignored: got acc=%h extra_done=%0d, want acc=11 extra_done=0", acc, seen_done);
    end
  endtask

  task automatic test_abort();
    int lat, seen_done;
    issue(OP_LDA, 8'h40, lat);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = OP_ADD;
    operand  = 8'h01;
    @(posedge clk);
    @(negedge clk);
    op_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({acc, flag_c, flag_z, flag_n, flag_v, op_ready, done} !== {8'h00, 4'b0000, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL abort_async: got acc=%h cznv=%b%b%b%b ready=%b done=%b, want acc=00 cznv=0000 ready=1 done=0",
               acc, flag_c, flag_z, flag_n, flag_v, op_ready, done);
    end
    // a command presented across a reset edge must be dropped
    op_valid = 1'b1;
    op_code  = OP_LDA;
    operand  = 8'h99;
    @(negedge clk);
    op_valid = 1'b0;
    rst = 1'b0;
    model_reset();
    seen_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) seen_done++;
    end
    checks++;
    if (seen_done != 0 || acc !== 8'h00 || op_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_done: got done_pulses=%0d acc=%h ready=%b, want 0 acc=00 ready=1",
               seen_done, acc, op_ready);
    end
  endtask

  task automatic test_random();
    int lat;
    logic [2:0] op;
    logic [7:0] val;
    for (int i = 0; i < 120; i++) begin
      op  = 3'($urandom_range(0, 7));
      val = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) val = 8'h00;
      if ($urandom_range(0, 7) == 0) val = 8'hFF;
      issue(op, val, lat);
      checks++;
      if ({acc, flag_c, flag_z, flag_n, flag_v} !== {8'(m_acc), m_c, m_z, m_n, m_v} || lat != 3) begin
        errors++;
        $display("FAIL random_op%0d: op=%0d b=%h got acc=%h cznv=%b%b%b%b lat=%0d, want acc=%h cznv=%b%b%b%b lat=3",
                 i, op, val, acc, flag_c, flag_z, flag_n, flag_v, lat,
                 8'(m_acc), m_c, m_z, m_n, m_v);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(OP_LDA, 8'h01, lat);
    for (int i = 0; i < 5; i++) begin
      issue(OP_ADD, 8'h01, lat);
      checks++;
      if (acc !== 8'(m_acc) || lat != 3) begin
        errors++;
        $display("FAIL back_to_back_%0d: got acc=%h lat=%0d, want acc=%h lat=3", i, acc, lat, 8'(m_acc));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    op_valid = 1'b0;
    op_code = OP_NOP;
    operand = 8'h00;
    model_reset();
    test_reset();
    test_overflow();
    test_subtract();
    test_carry_chain();
    test_compare();
    test_busy();
    test_back_to_back();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
